// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the RPN-CPU fetch sequencer: widths, attention-event
// bit positions and the run-control state encoding.
package fetch_sequencer_pkg;

  localparam int ADDR_W  = 8;
  localparam int NUM_EVT = 8;
  localparam int SEL_W   = 3;

  localparam int EVT_PUSH = 0;
  localparam int EVT_POP  = 1;
  localparam int EVT_ADD  = 2;
  localparam int EVT_MULT = 3;
  localparam int EVT_OFLW = 4;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_PAUSE = 2'd1,
    FS_STEP  = 2'd2
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode/control bundle between the CPU core and the fetch sequencer.
// The master drives the decode and run-control inputs. The slave (the sequencer) returns pc and status.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = fetch_sequencer_pkg::ADDR_W,
  parameter int NUM_EVT = fetch_sequencer_pkg::NUM_EVT,
  parameter int SEL_W   = fetch_sequencer_pkg::SEL_W
);
  logic               tick;
  logic               run;
  logic               step;
  logic [NUM_EVT-1:0] evt_in;
  logic               jmp_taken;
  logic [ADDR_W-1:0]  jmp_addr;
  logic               atc_req;
  logic [SEL_W-1:0]   atc_sel;
  logic [ADDR_W-1:0]  atc_addr;
  logic [ADDR_W-1:0]  pc;
  logic               exec_en;
  logic [NUM_EVT-1:0] flags;
  logic               paused;

  modport master (
    output tick, run, step, evt_in, jmp_taken, jmp_addr, atc_req, atc_sel, atc_addr,
    input  pc, exec_en, flags, paused
  );

  modport slave (
    input  tick, run, step, evt_in, jmp_taken, jmp_addr, atc_req, atc_sel, atc_addr,
    output pc, exec_en, flags, paused
  );
endinterface

// File: rtl/fetch_sequencer_atc_flag_bank.sv
// Sticky attention flags: rising-edge capture of event levels, plus single-bit
// consumption when an executing ATC finds its selected flag set.
module atc_flag_bank #(
  parameter int NUM_EVT = 8,
  parameter int SEL_W   = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               consume_en_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic               hit_o,
  output logic [NUM_EVT-1:0] flags_o
);
  import fetch_sequencer_pkg::*;

  logic [NUM_EVT-1:0] evt_prev_q;
  logic [NUM_EVT-1:0] flags_q, flags_d;
  logic [NUM_EVT-1:0] rise, seen, consume_mask;
  logic               hit;

  // A rise in the same cycle as the ATC counts as a hit, so it is consumed at once.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    hit          = 1'b0;
    consume_mask = '0;
    rise         = evt_i & ~evt_prev_q;
    seen         = flags_q | rise;
    if (int'(sel_i) < NUM_EVT) begin
      hit                 = seen[sel_i];
      consume_mask[sel_i] = consume_en_i & seen[sel_i];
    end
    flags_d = seen & ~consume_mask;
  end

  // Edge history keeps tracking through reset so a level held across reset is not seen as a rise.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
    evt_prev_q <= evt_i;
    if (reset_i) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign hit_o   = hit;
  assign flags_o = flags_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run/pause/step control for the RPN-calculator CPU.
// Chooses jump, ATC branch or sequential next address on each executing tick.
module fetch_sequencer #(
  parameter int ADDR_W  = fetch_sequencer_pkg::ADDR_W,
  parameter int NUM_EVT = fetch_sequencer_pkg::NUM_EVT,
  parameter int SEL_W   = fetch_sequencer_pkg::SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);
  import fetch_sequencer_pkg::*;

  fs_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               exec_en;
  logic               paused;
  logic               atc_hit;
  logic [NUM_EVT-1:0] flags;

  // A jump that is decoded together with an ATC blocks the ATC from consuming its flag.
  atc_flag_bank #(.NUM_EVT(NUM_EVT), .SEL_W(SEL_W)) u_flag_bank (
    .clk_i        (clk),
    .reset_i      (reset),
    .evt_i        (bus.evt_in),
    .consume_en_i (exec_en & bus.atc_req & ~bus.jmp_taken),
    .sel_i        (bus.atc_sel),
    .hit_o        (atc_hit),
    .flags_o      (flags)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= bus.run ? FS_RUN : FS_PAUSE;
    else       state_q <= state_d;
  end

  // STEP leaves only on a tick; a run request during STEP is picked up from PAUSE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_RUN:   if (!bus.run) state_d = FS_PAUSE;
      FS_PAUSE: if (bus.run) state_d = FS_RUN;
                else if (bus.step) state_d = FS_STEP;
      FS_STEP:  if (bus.tick) state_d = FS_PAUSE;
      default:  state_d = FS_PAUSE;
    endcase
  end

  always_comb begin
    exec_en = ~reset & bus.tick & ((state_q == FS_RUN) | (state_q == FS_STEP));
    paused  = (state_q == FS_PAUSE);
  end

  always_comb begin
    pc_d = pc_q;
    if (exec_en) begin
      if (bus.jmp_taken)                pc_d = bus.jmp_addr;
      else if (bus.atc_req && atc_hit)  pc_d = bus.atc_addr;
      else                              pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign bus.pc      = pc_q;
  assign bus.exec_en = exec_en;
  assign bus.flags   = flags;
  assign bus.paused  = paused;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random traffic,
// each cycle predicted by a behavioural model and checked by a separate monitor.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  typedef struct {
    bit       reset;
    bit       run;
    bit       step;
    bit       tick;
    bit [7:0] evt;
    bit       jmp;
    bit [7:0] jaddr;
    bit       atc;
    bit [2:0] sel;
    bit [7:0] aaddr;
  } stim_t;

  typedef struct {
    bit [7:0] pc;
    bit       exec_en;
    bit [7:0] flags;
    bit       paused;
  } exp_t;

  localparam int M_RUN   = 0;
  localparam int M_PAUSE = 1;
  localparam int M_STEP  = 2;

  logic clk = 1'b0;
  logic reset;
  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int       m_pc    = 0;
  bit [7:0] m_flags = '0;
  bit [7:0] m_prev  = '0;
  int       m_mode  = M_PAUSE;
  bit       m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle(input bit run, input bit tick);
    stim_t s;
    s = '{default: '0};
    s.run  = run;
    s.tick = tick;
    return s;
  endfunction

  // Drive one cycle at the falling edge, queue what the outputs must show, then advance the model.
  task automatic cycle(input stim_t s);
    exp_t     e;
    bit [7:0] seen;
    bit       exec;
    @(negedge clk);
    reset         = s.reset;
    bus.run       = s.run;
    bus.step      = s.step;
    bus.tick      = s.tick;
    bus.evt_in    = s.evt;
    bus.jmp_taken = s.jmp;
    bus.jmp_addr  = s.jaddr;
    bus.atc_req   = s.atc;
    bus.atc_sel   = s.sel;
    bus.atc_addr  = s.aaddr;

    exec = !s.reset && s.tick && (m_mode != M_PAUSE);
    if (m_known) begin
      e.pc      = m_pc[7:0];
      e.exec_en = exec;
      e.flags   = m_flags;
      e.paused  = (m_mode == M_PAUSE);
      exp_q.push_back(e);
    end

    if (s.reset) begin
      m_pc    = 0;
      m_flags = '0;
      m_mode  = s.run ? M_RUN : M_PAUSE;
      m_known = 1'b1;
    end else begin
      seen = m_flags | (s.evt & ~m_prev);
      if (exec) begin
        if (s.jmp) m_pc = s.jaddr;
        else if (s.atc && int'(s.sel) < NUM_EVT && seen[s.sel]) begin
          m_pc         = s.aaddr;
          seen[s.sel]  = 1'b0;
        end else m_pc = (m_pc + 1) % 256;
      end
      m_flags = seen;
      case (m_mode)
        M_RUN:   if (!s.run) m_mode = M_PAUSE;
        M_PAUSE: if (s.run) m_mode = M_RUN; else if (s.step) m_mode = M_STEP;
        default: if (s.tick) m_mode = M_PAUSE;
      endcase
    end
    m_prev = s.evt;
  endtask

  // Monitor: compares outputs mid-low-phase against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc",      bus.pc,      e.pc);
        check("sb_exec_en", bus.exec_en, e.exec_en);
        check("sb_flags",   bus.flags,   e.flags);
        check("sb_paused",  bus.paused,  e.paused);
      end
    end
  end

  initial begin
    stim_t    s;
    bit       run_lvl;
    bit [7:0] evt_lvl;

    // Free run from reset wraps 255 -> 0.
    s = idle(1, 1); s.reset = 1; cycle(s);
    s.reset = 0;
    repeat (256) cycle(s);
    s.tick = 0; cycle(s);
    #4 check("wrap_pc", bus.pc, 0);

    // Event pulse then ATC: branch taken and flag consumed; repeat ATC falls through.
    s = idle(1, 0); s.reset = 1; cycle(s);
    s.reset = 0; s.evt = 8'(1 << EVT_PUSH); cycle(s);
    s.evt = 0; s.tick = 1; s.atc = 1; s.sel = 3'(EVT_PUSH); s.aaddr = 5; cycle(s);
    #4 check("atc_exec_en", bus.exec_en, 1);
    check("push_flag_set", bus.flags[EVT_PUSH], 1);
    s.aaddr = 9; cycle(s);
    #4 check("atc_taken_pc", bus.pc, 5);
    check("push_consumed", bus.flags[EVT_PUSH], 0);
    s = idle(1, 0); cycle(s);
    #4 check("atc_fallthrough_pc", bus.pc, 6);

    // Same-cycle rise absorbed by its ATC; concurrent rise on another bit retained.
    s = idle(1, 1); s.atc = 1; s.sel = 3'(EVT_POP); s.aaddr = 23;
    s.evt = 8'((1 << EVT_POP) | (1 << EVT_ADD)); cycle(s);
    s = idle(1, 0); s.evt = 8'((1 << EVT_POP) | (1 << EVT_ADD)); cycle(s);
    #4 check("atc_same_cycle_pc", bus.pc, 23);
    check("flags_after_absorb", bus.flags, 8'h04);

    // Jump together with a hitting ATC: jump wins, nothing consumed.
    s = idle(1, 0); s.evt = 8'(1 << EVT_PUSH); cycle(s);
    s.tick = 1; s.jmp = 1; s.jaddr = 17; s.atc = 1; s.sel = 3'(EVT_PUSH); s.aaddr = 99; cycle(s);
    s = idle(1, 0); s.evt = 8'(1 << EVT_PUSH); cycle(s);
    #4 check("jmp_wins_pc", bus.pc, 17);
    check("jmp_keeps_flags", bus.flags, 8'h05);

    // Pause at 9, single step to 10, then resume.
    s = idle(1, 1); s.jmp = 1; s.jaddr = 9; cycle(s);
    s = idle(0, 0); cycle(s);
    s = idle(0, 1); repeat (20) cycle(s);
    #4 check("pause_hold_pc", bus.pc, 9);
    check("pause_paused", bus.paused, 1);
    s.step = 1; cycle(s);
    s.step = 0; cycle(s);
    repeat (5) cycle(s);
    #4 check("step_once_pc", bus.pc, 10);
    check("step_back_paused", bus.paused, 1);
    s = idle(1, 1); cycle(s);
    repeat (3) cycle(s);
    #4 check("resume_pc", bus.pc, 12);

    // Reset in STEP at pc=40 with flags 0x11.
    s = idle(1, 0); s.reset = 1; cycle(s);
    s = idle(1, 1); s.jmp = 1; s.jaddr = 40; cycle(s);
    s = idle(0, 0); cycle(s);
    s.evt = 8'h11; cycle(s);
    s.step = 1; cycle(s);
    #4 check("pre_reset_flags", bus.flags, 8'h11);
    s.step = 0; cycle(s);
    #4 check("pre_reset_in_step", bus.paused, 0);
    s.reset = 1; s.tick = 1; cycle(s);
    s = idle(0, 1); cycle(s);
    #4 check("post_reset_pc", bus.pc, 0);
    check("post_reset_flags", bus.flags, 0);
    check("post_reset_exec_en", bus.exec_en, 0);

    // Random traffic.
    run_lvl = 1;
    evt_lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) run_lvl = ~run_lvl;
      evt_lvl ^= 8'($urandom & $urandom & $urandom);
      s.reset = ($urandom_range(63) == 0);
      s.run   = run_lvl;
      s.step  = ($urandom_range(5) == 0);
      s.tick  = ($urandom_range(3) != 0);
      s.evt   = evt_lvl;
      s.jmp   = ($urandom_range(7) == 0);
      s.jaddr = 8'($urandom);
      s.atc   = ($urandom_range(2) == 0);
      s.sel   = 3'($urandom);
      s.aaddr = 8'($urandom);
      cycle(s);
    end

    repeat (2) @(negedge clk);
    #6 check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
